// File: rtl/hud_pkg.sv
// hud_pkg: shared sprite geometry, colour type and blink state encoding for the HUD heart renderer.
package hud_pkg;
    localparam int SPRITE_W = 20;
    localparam int SPRITE_H = 20;
    typedef logic [5:0] colour_t;
    localparam colour_t TRANSPARENT = 6'b000000;
    typedef enum logic {ST_IDLE, ST_BLINK} blink_state_t;
endpackage

// File: rtl/hud_lives_ctrl.sv
// hud_lives_ctrl: lives counter, frame-synchronous display snapshot and lost-heart blink.
// The blink FSM is built only when HUD_BLINK_EN is defined; otherwise the ghost heart is never shown.
module hud_lives_ctrl
    import hud_pkg::*;
#(
    parameter int MAX_LIVES    = 5,
    parameter int START_LIVES  = 3,
    parameter int BLINK_PERIOD = 8,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_frame_tick,
    input  logic       i_life_lost,
    input  logic       i_life_gain,
    output logic [2:0] o_lives,
    output logic [3:0] o_disp_lives,
    output logic [3:0] o_ghost_slot,
    output logic       o_ghost_active,
    output logic       o_game_over
);
    localparam logic [3:0] MAX_L   = 4'(MAX_LIVES);
    localparam logic [3:0] START_L = 4'(START_LIVES);

    logic [3:0] r_lives, r_disp, w_lives_nxt;
    logic       r_game_over, w_dec, w_inc;

    assign w_dec       = i_life_lost && !i_life_gain && r_lives != 4'd0;
    assign w_inc       = i_life_gain && !i_life_lost && r_lives < MAX_L;
    assign w_lives_nxt = w_dec ? r_lives - 4'd1 : w_inc ? r_lives + 4'd1 : r_lives;

    // the snapshot takes the pre-event count, so an event on frame_tick lands next frame
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lives     <= START_L;
            r_disp      <= START_L;
            r_game_over <= 1'b0;
        end else begin
            r_lives     <= w_lives_nxt;
            r_game_over <= w_lives_nxt == 4'd0;
            if (i_frame_tick) r_disp <= r_lives;
        end
    end

    assign o_lives      = r_lives[2:0];
    assign o_disp_lives = r_disp;
    assign o_game_over  = r_game_over;

`ifdef HUD_BLINK_EN
    localparam int CW = $clog2(BLINK_FRAMES) + 1;
    localparam logic [CW-1:0] LAST = CW'(BLINK_FRAMES - 1);
    localparam logic [CW-1:0] BP   = CW'(BLINK_PERIOD);

    blink_state_t  r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt, w_half;
    logic [3:0]    r_ghost, w_ghost;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ghost <= '0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_ghost <= w_ghost;
        end
    end

    // a new loss always restarts the blink on the heart just lost
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_ghost = r_ghost;
        if (w_dec) begin
            w_state = ST_BLINK;
            w_cnt   = '0;
            w_ghost = w_lives_nxt;
        end else if (r_state == ST_BLINK && w_inc) begin
            w_state = ST_IDLE;
            w_cnt   = '0;
        end else if (r_state == ST_BLINK && i_frame_tick) begin
            w_state = r_cnt == LAST ? ST_IDLE : ST_BLINK;
            w_cnt   = r_cnt == LAST ? '0 : r_cnt + 1'b1;
        end
    end

    assign w_half         = r_cnt / BP;
    assign o_ghost_slot   = r_ghost;
    assign o_ghost_active = r_state == ST_BLINK && !w_half[0];
`else
    assign o_ghost_slot   = 4'd0;
    assign o_ghost_active = 1'b0;
`endif
endmodule

// File: rtl/hud_heart_renderer.sv
// hud_heart_renderer: maps the scan position onto a row of heart sprites and emits a 3-cycle aligned HUD pixel.
// Define HUD_BLINK_EN to blink a just-lost heart; the default build drops it at the next frame.
module hud_heart_renderer
    import hud_pkg::*;
#(
    parameter int HUD_X        = 8,
    parameter int HUD_Y        = 4,
    parameter int HEART_PITCH  = 24,
    parameter int MAX_LIVES    = 5,
    parameter int START_LIVES  = 3,
    parameter int BLINK_PERIOD = 8,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] i_h_count,
    input  logic [9:0] i_v_count,
    input  logic       i_frame_tick,
    input  logic       i_life_lost,
    input  logic       i_life_gain,
    output logic [4:0] o_sprite_x,
    output logic [4:0] o_sprite_y,
    input  colour_t    i_pixel_data,
    output colour_t    o_hud_pixel,
    output logic       o_hud_valid,
    output logic [2:0] o_lives,
    output logic       o_game_over
);
    localparam logic [9:0] X0    = 10'(HUD_X);
    localparam logic [9:0] Y0    = 10'(HUD_Y);
    localparam logic [9:0] ROW_W = 10'(MAX_LIVES * HEART_PITCH);
    localparam logic [9:0] SW    = 10'(SPRITE_W);
    localparam logic [9:0] SH    = 10'(SPRITE_H);

    logic [3:0] w_disp, w_ghost_slot, w_slot;
    logic [9:0] w_dx, w_dy, w_ox;
    logic       w_ghost_active, w_shown, w_hit;
    logic [4:0] r_sprite_x, r_sprite_y;
    logic       r_hit1, r_hit2, r_valid;
    colour_t    r_pixel;

    hud_lives_ctrl #(
        .MAX_LIVES   (MAX_LIVES),
        .START_LIVES (START_LIVES),
        .BLINK_PERIOD(BLINK_PERIOD),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_lives (
        .clk           (clk),
        .rst           (rst),
        .i_frame_tick  (i_frame_tick),
        .i_life_lost   (i_life_lost),
        .i_life_gain   (i_life_gain),
        .o_lives       (o_lives),
        .o_disp_lives  (w_disp),
        .o_ghost_slot  (w_ghost_slot),
        .o_ghost_active(w_ghost_active),
        .o_game_over   (o_game_over)
    );

    assign w_dx = i_h_count - X0;
    assign w_dy = i_v_count - Y0;

    // slot from the highest pitch boundary passed; avoids a divider
    always_comb begin
        w_slot = 4'd0;
        w_ox   = w_dx;
        for (int k = 1; k < MAX_LIVES; k++)
            if (w_dx >= 10'(k * HEART_PITCH)) begin
                w_slot = 4'(k);
                w_ox   = w_dx - 10'(k * HEART_PITCH);
            end
    end

    assign w_shown = w_slot < w_disp || (w_ghost_active && w_slot == w_ghost_slot);
    assign w_hit   = i_h_count >= X0 && w_dx < ROW_W && i_v_count >= Y0 && w_dy < SH
                   && w_ox < SW && w_shown;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sprite_x <= '0;
            r_sprite_y <= '0;
            r_hit1     <= 1'b0;
            r_hit2     <= 1'b0;
            r_pixel    <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_sprite_x <= w_ox[4:0];
            r_sprite_y <= w_dy[4:0];
            r_hit1     <= w_hit;
            r_hit2     <= r_hit1;
            r_pixel    <= i_pixel_data;
            r_valid    <= r_hit2 && i_pixel_data != TRANSPARENT;
        end
    end

    assign o_sprite_x  = r_sprite_x;
    assign o_sprite_y  = r_sprite_y;
    assign o_hud_pixel = r_pixel;
    assign o_hud_valid = r_valid;
endmodule

// File: tb/tb_hud_heart_renderer.sv
// tb_hud_heart_renderer: directed scans and life events against a scoreboard of hand-derived HUD pixels.
module tb_hud_heart_renderer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] h = '0, v = '0;
    logic       ft = 1'b0, lost = 1'b0, gain = 1'b0;
    logic [4:0] sx, sy;
    logic [5:0] pix = '0, hp;
    logic       hv, go;
    logic [2:0] lives;
    int         cyc = 0;
    int         n_tests = 0, n_fail = 0;

    typedef struct { int stamp; logic [4:0] x; logic [4:0] y; } sp_t;
    typedef struct { int stamp; logic vld; logic [5:0] px; } px_t;
    sp_t qs[$];
    px_t qp[$];

    always #5 clk = ~clk;

    hud_heart_renderer dut (
        .clk         (clk),
        .rst         (rst),
        .i_h_count   (h),
        .i_v_count   (v),
        .i_frame_tick(ft),
        .i_life_lost (lost),
        .i_life_gain (gain),
        .o_sprite_x  (sx),
        .o_sprite_y  (sy),
        .i_pixel_data(pix),
        .o_hud_pixel (hp),
        .o_hud_valid (hv),
        .o_lives     (lives),
        .o_game_over (go)
    );

    // ROM model: one-cycle registered read, data encodes the address
    always @(posedge clk) pix <= {sy[2:0], sx[2:0]};
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (qs.size() > 0 && qs[0].stamp + 1 == cyc) begin
            check("sprite_x", int'(sx), int'(qs[0].x));
            check("sprite_y", int'(sy), int'(qs[0].y));
            void'(qs.pop_front());
        end
        if (qp.size() > 0 && qp[0].stamp + 3 == cyc) begin
            check("hud_valid", int'(hv), int'(qp[0].vld));
            if (qp[0].vld) check("hud_pixel", int'(hp), int'(qp[0].px));
            void'(qp.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(logic l, logic g, logic f);
        lost = l;
        gain = g;
        ft   = f;
        step();
        lost = 1'b0;
        gain = 1'b0;
        ft   = 1'b0;
    endtask

    task automatic scan(int vv, int h0, int h1, logic [4:0] mask);
        for (int hh = h0; hh <= h1; hh++) begin
            int dx, dy, slot, ox;
            logic hit;
            logic [5:0] px;
            h = 10'(hh);
            v = 10'(vv);
            dx = hh - 8;
            dy = vv - 4;
            hit = 1'b0;
            px = '0;
            if (dx >= 0 && dx < 120 && dy >= 0 && dy < 20) begin
                slot = dx / 24;
                ox = dx % 24;
                if (ox < 20) begin
                    qs.push_back('{cyc, 5'(ox), 5'(dy)});
                    hit = mask[slot];
                    px = {3'(dy), 3'(ox)};
                end
            end
            qp.push_back('{cyc, hit && px != 6'd0, px});
            step();
        end
        h = '0;
        v = '0;
        repeat (4) step();
    endtask

    task automatic summary();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    endtask

    initial begin
        repeat (3) step();
        check("rst_lives", int'(lives), 3);
        check("rst_game_over", int'(go), 0);
        check("rst_hud_valid", int'(hv), 0);
        check("rst_sprite_x", int'(sx), 0);
        check("rst_sprite_y", int'(sy), 0);
        rst = 1'b0;
        step();
        check("lives_after_rst", int'(lives), 3);
        scan(9, 0, 130, 5'b00111);
        scan(4, 0, 60, 5'b00111);
        scan(23, 50, 80, 5'b00111);
        scan(24, 0, 40, 5'b00111);
        scan(3, 0, 40, 5'b00111);
        pulse(1'b1, 1'b0, 1'b0);
        check("lost_lives", int'(lives), 2);
        check("lost_game_over", int'(go), 0);
        scan(9, 50, 80, 5'b00111);
        pulse(1'b0, 1'b0, 1'b1);
`ifdef HUD_BLINK_EN
        scan(9, 50, 80, 5'b00111);
        repeat (7) pulse(1'b0, 1'b0, 1'b1);
        scan(9, 50, 80, 5'b00011);
        repeat (8) pulse(1'b0, 1'b0, 1'b1);
        scan(9, 50, 80, 5'b00111);
        repeat (48) pulse(1'b0, 1'b0, 1'b1);
        scan(9, 50, 80, 5'b00011);
`else
        scan(9, 50, 80, 5'b00011);
`endif
        pulse(1'b1, 1'b1, 1'b0);
        check("simul_lives", int'(lives), 2);
        pulse(1'b1, 1'b0, 1'b0);
        check("lost2_lives", int'(lives), 1);
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b0, 1'b1, 1'b0);
        check("gain_cancel_lives", int'(lives), 2);
        scan(9, 20, 60, 5'b00001);
        pulse(1'b0, 1'b1, 1'b0);
        check("gain_3", int'(lives), 3);
        pulse(1'b0, 1'b1, 1'b0);
        check("gain_4", int'(lives), 4);
        pulse(1'b0, 1'b1, 1'b0);
        check("gain_5", int'(lives), 5);
        pulse(1'b0, 1'b1, 1'b0);
        check("gain_sat", int'(lives), 5);
        pulse(1'b0, 1'b0, 1'b1);
        scan(9, 0, 130, 5'b11111);
        pulse(1'b1, 1'b0, 1'b1);
        check("lost_on_tick", int'(lives), 4);
        scan(9, 100, 130, 5'b11111);
        pulse(1'b0, 1'b0, 1'b1);
`ifdef HUD_BLINK_EN
        scan(9, 100, 130, 5'b11111);
`else
        scan(9, 100, 130, 5'b01111);
`endif
        for (int i = 3; i >= 1; i--) begin
            pulse(1'b1, 1'b0, 1'b0);
            check("drain_lives", int'(lives), i);
        end
        check("go_at_1", int'(go), 0);
        pulse(1'b1, 1'b0, 1'b0);
        check("lives_zero", int'(lives), 0);
        check("go_at_0", int'(go), 1);
        pulse(1'b1, 1'b0, 1'b0);
        check("lost_sat", int'(lives), 0);
        check("go_sat", int'(go), 1);
        pulse(1'b0, 1'b0, 1'b1);
`ifdef HUD_BLINK_EN
        scan(9, 0, 40, 5'b00001);
`else
        scan(9, 0, 40, 5'b00000);
`endif
        check("queue_drain", qs.size() + qp.size(), 0);
        summary();
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        summary();
        $finish;
    end
endmodule
